// File: rtl/fetch_buffer_pkg.sv
// Shared widths and encodings for the fetch front end.
package fetch_buffer_pkg;
  localparam int RomAddr  = 6;
  localparam int DataSize = 32;
  // RISC-V canonical NOP (addi x0, x0, 0)
  localparam logic [31:0] NopInst = 32'h00000013;
endpackage

// File: rtl/fetch_buffer_if.sv
// Valid/ready handshake from the fetch queue head into IF/ID.
interface fetch_buffer_if
  import fetch_buffer_pkg::*;
#(
  parameter int ADDR_W = RomAddr,
  parameter int DATA_W = DataSize
);
  logic              outValid;
  logic              outReady;
  logic [ADDR_W-1:0] outAddr;
  logic [DATA_W-1:0] outInst;

  modport master (output outValid, output outAddr, output outInst, input outReady);
  modport slave  (input outValid, input outAddr, input outInst, output outReady);
endinterface

// File: rtl/fetch_queue.sv
// Circular queue of {addr, inst} entries with push/pop/flush and head read.
module fetch_queue
  import fetch_buffer_pkg::*;
#(
  parameter int ADDR_W = RomAddr,
  parameter int DATA_W = DataSize,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       resetIn,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          wrAddr,
  input  logic [DATA_W-1:0]          wrInst,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       headValid,
  output logic [ADDR_W-1:0]          headAddr,
  output logic [DATA_W-1:0]          headInst
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] instMem [DEPTH];

  always_ff @(posedge clk) begin
    if (resetIn || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (push && !resetIn && !flush) begin
      addrMem[wrPtr] <= wrAddr;
      instMem[wrPtr] <= wrInst;
    end
  end

  assign headValid = (count != '0);
  assign headAddr  = addrMem[rdPtr];
  assign headInst  = headValid ? instMem[rdPtr] : NopInst;
endmodule

// File: rtl/fetch_buffer.sv
// Fetch PC owner: drives the ROM address, queues fetched words, handles redirect.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int                ADDR_W     = RomAddr,
  parameter int                DATA_W     = DataSize,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       resetIn,
  input  logic                       enable,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirectAddr,
  output logic [ADDR_W-1:0]          romAddr,
  output logic                       romReq,
  input  logic [DATA_W-1:0]          romInst,
  fetch_buffer_if.master             out,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] fetchPc;
  logic              push;
  logic              pop;
  logic              flush;
  logic              headValid;

  // Redirect wins over any handshake in the same cycle; enable masks everything.
  assign flush = enable && redirect;
  assign pop   = enable && headValid && out.outReady && !redirect;
  assign push  = enable && !resetIn && !redirect && ((count < CW'(DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (resetIn)    fetchPc <= RESET_ADDR;
    else if (flush) fetchPc <= redirectAddr;
    else if (push)  fetchPc <= fetchPc + 1'b1;
  end

  assign romAddr = fetchPc;
  assign romReq  = push;

  fetch_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) queue (
    .clk       (clk),
    .resetIn   (resetIn),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .wrAddr    (fetchPc),
    .wrInst    (romInst),
    .count     (count),
    .headValid (headValid),
    .headAddr  (out.outAddr),
    .headInst  (out.outInst)
  );

  assign out.outValid = headValid;
endmodule
